// File: rtl/axi_master_pkg.sv
// rtl/axi_master_pkg.sv - shared state encoding and AXI constants for the single-beat master
package axi_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    READA,
    READD
  } state_e;

  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B     = 3'd3;
  localparam int         AXI_DATA_WIDTH  = 64;
  localparam int         AXI_STRB_WIDTH  = AXI_DATA_WIDTH / 8;

  // Both error encodings share resp[1]; OKAY and EXOKAY count as success.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_single_master_if.sv
// rtl/axi_single_master_if.sv - single-beat AXI4 channels between master and slave
interface axi_single_master_if
  import axi_master_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);

  logic                      aw_valid;
  logic                      aw_ready;
  logic [ADDR_W-1:0]         aw_addr;
  logic [ID_W-1:0]           aw_id;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;

  logic                      w_valid;
  logic                      w_ready;
  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;

  logic                      b_valid;
  logic                      b_ready;
  logic [1:0]                b_resp;

  logic                      ar_valid;
  logic                      ar_ready;
  logic [ADDR_W-1:0]         ar_addr;
  logic [ID_W-1:0]           ar_id;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;

  logic                      r_valid;
  logic                      r_ready;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;

  modport master (
    output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_resp,
    output b_ready,
    output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
    input  ar_ready,
    input  r_valid, r_data, r_resp, r_last,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_resp,
    input  b_ready,
    input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_data, r_resp, r_last,
    input  r_ready
  );

endinterface

// File: rtl/axi_single_master.sv
// rtl/axi_single_master.sv - one-outstanding single-beat AXI4 master driven by a simple request port
module axi_single_master
  import axi_master_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MST_ID         = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [63:0]               req_wdata,
  input  logic [7:0]                req_strb,

  output logic                      rsp_valid,
  output logic [63:0]               rsp_rdata,
  output logic                      rsp_err,

  axi_single_master_if.master       axi
);

  state_e                    state_q, state_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [63:0]               wdata_q, wdata_d;
  logic [7:0]                strb_q, strb_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_err_q, rsp_err_d;
  logic [63:0]               rsp_rdata_q, rsp_rdata_d;
  logic                      aw_hs, w_hs;
  logic                      unused_r_last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // AW and W retire independently; the write leaves WRITE once both have been taken.
  assign aw_hs = axi.aw_valid && axi.aw_ready;
  assign w_hs  = axi.w_valid && axi.w_ready;

  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          strb_d    = req_strb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_we ? WRITE : READA;
        end
      end
      WRITE: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WRESP;
      end
      WRESP: begin
        if (axi.b_valid) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = resp_is_err(axi.b_resp);
          state_d     = IDLE;
        end
      end
      READA: begin
        if (axi.ar_ready) state_d = READD;
      end
      READD: begin
        if (axi.r_valid) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = resp_is_err(axi.r_resp);
          rsp_rdata_d = axi.r_data;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  assign axi.aw_valid = (state_q == WRITE) && !aw_done_q;
  assign axi.aw_addr  = addr_q;
  assign axi.aw_id    = AXI_ID_WIDTH'(MST_ID);
  assign axi.aw_len   = 8'd0;
  assign axi.aw_size  = AXI_SIZE_8B;
  assign axi.aw_burst = AXI_BURST_INCR;

  assign axi.w_valid  = (state_q == WRITE) && !w_done_q;
  assign axi.w_data   = wdata_q;
  assign axi.w_strb   = strb_q;
  assign axi.w_last   = 1'b1;

  assign axi.b_ready  = (state_q == WRESP);

  assign axi.ar_valid = (state_q == READA);
  assign axi.ar_addr  = addr_q;
  assign axi.ar_id    = AXI_ID_WIDTH'(MST_ID);
  assign axi.ar_len   = 8'd0;
  assign axi.ar_size  = AXI_SIZE_8B;
  assign axi.ar_burst = AXI_BURST_INCR;

  assign axi.r_ready  = (state_q == READD);

  // Every read is a single beat, so the last flag carries no information.
  assign unused_r_last = axi.r_last;

endmodule

// File: tb/tb_axi_single_master.sv
// tb/tb_axi_single_master.sv - randomized and directed bench for axi_single_master against a transaction model
module tb_axi_single_master;

  localparam int AW  = 32;
  localparam int IDW = 4;
  localparam int MID = 5;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [63:0]   req_wdata;
  logic [7:0]    req_strb;
  logic          rsp_valid, rsp_err;
  logic [63:0]   rsp_rdata;

  axi_single_master_if #(.ADDR_W(AW), .ID_W(IDW)) axi ();

  axi_single_master #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IDW), .MST_ID(MID)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .axi       (axi)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Slave behaviour knobs: a negative fix_* means a random delay/response.
  int          fix_aw = 0, fix_w = 0, fix_ar = 0, fix_b = 0, fix_r = 0;
  int          fix_resp = 0;
  int          max_dly = 3;
  logic        fix_rdata_en = 1'b0;
  logic [63:0] fix_rdata = '0;
  logic        flush = 1'b0;

  function automatic int dly(input int fix);
    return (fix >= 0) ? fix : int'($urandom_range(0, max_dly));
  endfunction

  function automatic logic [1:0] pick_resp();
    return (fix_resp >= 0) ? fix_resp[1:0] : 2'($urandom_range(0, 3));
  endfunction

  initial begin : slave
    int   aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic p_awv, p_wv, p_arv, p_br, p_rr;
    logic s_aw, s_w, s_ar;
    axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0;
    axi.b_valid = 0; axi.b_resp = 0;
    axi.r_valid = 0; axi.r_data = 0; axi.r_resp = 0; axi.r_last = 1;
    {p_awv, p_wv, p_arv, p_br, p_rr, s_aw, s_w, s_ar} = '0;
    {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
    forever begin
      @(posedge clk); #1;
      if (p_awv && axi.aw_ready) s_aw = 1;
      if (p_wv && axi.w_ready)   s_w  = 1;
      if (p_arv && axi.ar_ready) s_ar = 1;
      if (axi.b_valid && p_br) begin axi.b_valid = 0; s_aw = 0; s_w = 0; end
      if (axi.r_valid && p_rr) begin axi.r_valid = 0; s_ar = 0; end
      if (flush) begin
        {s_aw, s_w, s_ar} = '0;
        axi.b_valid = 0; axi.r_valid = 0;
      end
      if (axi.aw_valid) begin
        if (aw_cnt == 0) axi.aw_ready = 1; else begin axi.aw_ready = 0; aw_cnt--; end
      end else begin axi.aw_ready = 0; aw_cnt = dly(fix_aw); end
      if (axi.w_valid) begin
        if (w_cnt == 0) axi.w_ready = 1; else begin axi.w_ready = 0; w_cnt--; end
      end else begin axi.w_ready = 0; w_cnt = dly(fix_w); end
      if (axi.ar_valid) begin
        if (ar_cnt == 0) axi.ar_ready = 1; else begin axi.ar_ready = 0; ar_cnt--; end
      end else begin axi.ar_ready = 0; ar_cnt = dly(fix_ar); end
      if (s_aw && s_w) begin
        if (!axi.b_valid) begin
          if (b_cnt == 0) begin axi.b_valid = 1; axi.b_resp = pick_resp(); end else b_cnt--;
        end
      end else b_cnt = dly(fix_b);
      if (s_ar) begin
        if (!axi.r_valid) begin
          if (r_cnt == 0) begin
            axi.r_valid = 1;
            axi.r_resp  = pick_resp();
            axi.r_data  = fix_rdata_en ? fix_rdata : {$urandom, $urandom};
          end else r_cnt--;
        end
      end else r_cnt = dly(fix_r);
      p_awv = axi.aw_valid; p_wv = axi.w_valid; p_arv = axi.ar_valid;
      p_br  = axi.b_ready;  p_rr = axi.r_ready;
    end
  end

  // Transaction-level model: one request in flight, channels retire on handshakes.
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [63:0]   wdata;
    logic [7:0]    strb;
  } txn_t;

  txn_t        m_cur;
  logic        m_live = 1'b0;
  logic        m_busy = 1'b0, m_aw = 1'b0, m_w = 1'b0, m_ar = 1'b0;
  logic        m_rsp_due = 1'b0, m_err = 1'b0;
  logic [63:0] m_rdata = '0;
  int          cyc = 0, n_req = 0, n_rsp = 0, n_wv = 0, n_br = 0, last_aw_cyc = 0;
  logic        last_rsp_err = 1'b0;
  int          req_cyc_q[$];
  int          rsp_cyc_q[$];

  always @(negedge clk) begin : compare
    logic e_awv, e_wv, e_arv, e_br, e_rr, was_busy;
    cyc++;
    e_awv = m_busy && m_cur.we && !m_aw;
    e_wv  = m_busy && m_cur.we && !m_w;
    e_arv = m_busy && !m_cur.we && !m_ar;
    e_br  = m_busy && m_cur.we && m_aw && m_w;
    e_rr  = m_busy && !m_cur.we && m_ar;
    if (m_live) begin
      chk("req_ready", req_ready, !m_busy);
      chk("aw_valid", axi.aw_valid, e_awv);
      chk("w_valid", axi.w_valid, e_wv);
      chk("ar_valid", axi.ar_valid, e_arv);
      chk("b_ready", axi.b_ready, e_br);
      chk("r_ready", axi.r_ready, e_rr);
      chk("rsp_valid", rsp_valid, m_rsp_due);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      if (m_rsp_due) chk("rsp_err", rsp_err, m_err);
      if (e_awv) chk("aw_fields", {axi.aw_addr, axi.aw_id, axi.aw_len, axi.aw_size, axi.aw_burst},
                     {m_cur.addr, 4'(MID), 8'd0, 3'd3, 2'b01});
      if (e_wv) begin
        chk("w_data", axi.w_data, m_cur.wdata);
        chk("w_strb_last", {axi.w_strb, axi.w_last}, {m_cur.strb, 1'b1});
      end
      if (e_arv) chk("ar_fields", {axi.ar_addr, axi.ar_id, axi.ar_len, axi.ar_size, axi.ar_burst},
                     {m_cur.addr, 4'(MID), 8'd0, 3'd3, 2'b01});
      if (rsp_valid) begin n_rsp++; rsp_cyc_q.push_back(cyc); last_rsp_err = rsp_err; end
      if (axi.w_valid) n_wv++;
      if (axi.b_ready) n_br++;
      if (axi.aw_valid && axi.aw_ready) last_aw_cyc = cyc;
    end
    if (rst_i) begin
      m_live = 1; m_busy = 0; m_aw = 0; m_w = 0; m_ar = 0;
      m_rsp_due = 0; m_err = 0; m_rdata = '0;
    end else if (m_live) begin
      was_busy  = m_busy;
      m_rsp_due = 0;
      if (e_awv && axi.aw_ready) m_aw = 1;
      if (e_wv && axi.w_ready)   m_w  = 1;
      if (e_arv && axi.ar_ready) m_ar = 1;
      if (e_br && axi.b_valid) begin m_busy = 0; m_rsp_due = 1; m_err = axi.b_resp[1]; end
      if (e_rr && axi.r_valid) begin
        m_busy = 0; m_rsp_due = 1; m_err = axi.r_resp[1]; m_rdata = axi.r_data;
      end
      if (!was_busy && req_valid) begin
        m_cur  = '{we: req_we, addr: req_addr, wdata: req_wdata, strb: req_strb};
        m_busy = 1; m_aw = 0; m_w = 0; m_ar = 0;
        n_req++;
        req_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [63:0] data,
                        input logic [7:0] strb);
    bit ok = 0;
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = data; req_strb = strb;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) chk("req_handshake_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp(input int target);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (n_rsp >= target) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("rsp_timeout", 64'(n_rsp), 64'(target));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : main
    int base;
    bit seen;
    rst_i = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_strb = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 0;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_outputs", {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready,
                          rsp_valid, rsp_err}, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);

    // Minimum-latency write.
    fix_aw = 0; fix_w = 0; fix_ar = 0; fix_b = 0; fix_r = 0; fix_resp = 0;
    base = n_rsp;
    do_req(1, 32'h4000_0010, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    req_valid = 0;
    wait_rsp(base + 1);
    chk("wr_aw_cycle", 64'(last_aw_cyc - req_cyc_q[$]), 1);
    chk("wr_latency", 64'(rsp_cyc_q[$] - req_cyc_q[$]), 3);
    chk("wr_err", last_rsp_err, 0);

    // W accepted four cycles after AW.
    fix_w = 4;
    cycles(2);
    base = n_rsp; n_wv = 0; n_br = 0;
    do_req(1, 32'h0000_1238, 64'h0102_0304_0506_0708, 8'h0F);
    req_valid = 0;
    wait_rsp(base + 1);
    cycles(3);
    chk("slow_w_valid_cycles", 64'(n_wv), 5);
    chk("slow_w_bready_cycles", 64'(n_br), 1);
    chk("slow_w_rsp_count", 64'(n_rsp - base), 1);
    fix_w = 0;

    // Read with SLVERR.
    fix_resp = 2; fix_rdata_en = 1; fix_rdata = 64'h1122_3344_5566_7788;
    base = n_rsp;
    do_req(0, 32'h0000_0008, '0, '0);
    req_valid = 0;
    wait_rsp(base + 1);
    chk("rd_rdata", rsp_rdata, 64'h1122_3344_5566_7788);
    chk("rd_err", last_rsp_err, 1);
    chk("rd_latency", 64'(rsp_cyc_q[$] - req_cyc_q[$]), 3);

    // Back-to-back read then write with req_valid held.
    fix_resp = 0;
    base = n_rsp;
    do_req(0, 32'h0000_0100, '0, '0);
    do_req(1, 32'h0000_0200, 64'hCAFE_F00D_0000_0001, 8'hA5);
    req_valid = 0;
    wait_rsp(base + 2);
    chk("b2b_no_gap", 64'(req_cyc_q[$] - rsp_cyc_q[$-1]), 0);

    // Reset while waiting in READD, then a late R beat.
    fix_r = 6;
    cycles(2);
    base = n_rsp;
    do_req(0, 32'h0000_0040, '0, '0);
    req_valid = 0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (axi.r_ready) begin seen = 1; break; end
    end
    chk("rst_reached_readd", seen, 1);
    @(posedge clk); #1 rst_i = 1;
    @(posedge clk); #1 rst_i = 0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      cycles(1);
      if (axi.r_valid) seen = 1;
    end
    chk("rst_late_r_present", seen, 1);
    chk("rst_r_ready", axi.r_ready, 0);
    chk("rst_no_rsp", 64'(n_rsp - base), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    flush = 1;
    cycles(1);
    flush = 0;
    cycles(1);

    // Randomized traffic.
    fix_aw = -1; fix_w = -1; fix_ar = -1; fix_b = -1; fix_r = -1; fix_resp = -1;
    fix_rdata_en = 0; max_dly = 3;
    base = n_rsp;
    for (int i = 0; i < 300; i++) begin
      do_req(1'($urandom), $urandom, {$urandom, $urandom}, 8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        req_valid = 0;
        cycles($urandom_range(0, 2));
      end
    end
    req_valid = 0;
    wait_rsp(base + 300);
    cycles(3);
    chk("rand_rsp_count", 64'(n_rsp - base), 300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_single_master.md
AXI_SINGLE_MASTER -- requirements
Module: axi_single_master

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, the AXI address width.
REQ-002 SHALL have parameter AXI_ID_WIDTH, default 4, the AXI ID width.
REQ-003 SHALL have parameter MST_ID, default 0, the fixed ID driven on aw_id/ar_id.
REQ-004 SHALL have clk_i  in  1  sole clock; all logic is rising-edge.
REQ-005 SHALL have rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have req_valid  in  1  client request present.
REQ-007 SHALL have req_ready  out  1  request accepted when high together with req_valid.
REQ-008 SHALL have req_we  in  1  1=write, 0=read.
REQ-009 SHALL have req_addr  in  AXI_ADDR_WIDTH  byte address.
REQ-010 SHALL have req_wdata  in  64  write data.
REQ-011 SHALL have req_strb  in  8  write byte enables.
REQ-012 SHALL have rsp_valid  out  1  one-cycle completion pulse, no backpressure.
REQ-013 SHALL have rsp_rdata  out  64  read data of the last completed read.
REQ-014 SHALL have rsp_err  out  1  completion status, 1=SLVERR/DECERR.
REQ-015 SHALL have aw_valid, aw_ready  out, in  1 each  write-address handshake.
REQ-016 SHALL have aw_addr  out  AXI_ADDR_WIDTH  write address.
REQ-017 SHALL have constant outputs aw_id/ar_id=MST_ID, aw_len/ar_len(8)=0, aw_size/ar_size(3)=3, aw_burst/ar_burst(2)=INCR, w_last(1)=1.
REQ-018 SHALL have w_valid, w_ready  out, in  1 each  write-data handshake.
REQ-019 SHALL have w_data  out  64  and w_strb  out  8  write beat.
REQ-020 SHALL have b_valid, b_ready  in, out  1 each  and b_resp  in  2  write response.
REQ-021 SHALL have ar_valid, ar_ready  out, in  1 each  and ar_addr  out  AXI_ADDR_WIDTH.
REQ-022 SHALL have r_valid, r_ready  in, out  1 each, r_data  in  64, r_resp  in  2.

Function
REQ-023 SHALL implement states IDLE, WRITE, WRESP, READA, READD; req_ready=1 only in IDLE; exactly one transaction outstanding.
REQ-024 SHALL, on request handshake, register addr/wdata/strb unmodified and go to WRITE (req_we=1) or READA (req_we=0), asserting aw_valid+w_valid or ar_valid from the next cycle.
REQ-025 SHALL in WRITE drop aw_valid and w_valid independently on their own handshakes, entering WRESP once both are done, whether in the same or different cycles, in either order.
REQ-026 SHALL never deassert any valid before its ready, and hold addr/data/strb stable while valid is high.
REQ-027 SHALL assert b_ready only in WRESP and r_ready only in READD; on the B or R handshake return to IDLE.
REQ-028 SHALL pulse rsp_valid for exactly one cycle, in the cycle after the B/R handshake, with rsp_err=resp[1]; req_ready is simultaneously high to allow back-to-back requests.
REQ-029 SHALL load rsp_rdata from r_data on the R handshake only; it holds its value through writes.
REQ-030 SHALL give a minimum latency, with all readies and responses immediate, of 3 cycles from request handshake to rsp_valid for both reads and writes.
REQ-031 SHALL ignore r_last, and SHALL ignore b_valid/r_valid arriving outside WRESP/READD.

Reset
REQ-032 SHALL, while rst_i is high at a clock edge, enter IDLE with all valids/readies=0, except req_ready=1 after reset, and rsp_valid=0, rsp_err=0, rsp_rdata=0, even mid-transaction; an in-flight AXI response arriving afterwards is ignored.

Structure
REQ-033 SHALL take the state enum and the AXI_RESP_*/AXI_BURST_INCR/size constants from shared package axi_master_pkg; no sub-module is needed.

Verification
REQ-034 SHALL cover: write addr=0x4000_0010, data=0xDEAD_BEEF_0123_4567, strb=0xFF, immediate readies, b_resp=0 -> aw/w at cycle 1, rsp_valid at cycle 3, rsp_err=0.
REQ-035 SHALL cover: write with w_ready 4 cycles after aw_ready -> w_valid held, w_data stable, single b_ready phase, single rsp_valid.
REQ-036 SHALL cover: read addr=0x8, r_data=0x1122_3344_5566_7788, r_resp=2 -> rsp_rdata=0x1122334455667788, rsp_err=1.
REQ-037 SHALL cover: back-to-back read then write with req_valid held -> second handshake in the rsp_valid cycle, no idle gap.
REQ-038 SHALL cover: rst_i pulse while in READD, followed by a late r_valid -> r_ready=0, no rsp_valid, rsp_rdata=0.
